// File: rtl/ci_cmd_sender_pkg.sv
// Shared definitions for the board-controller command sender: FSM encoding,
// guard byte and controller opcodes.
package ci_cmd_sender_pkg;

  typedef enum logic [1:0] {IDLE, GUARD, CMD, GAP} state_e;

  localparam logic [7:0] GUARD_BYTE = 8'hFF;

  localparam logic [2:0] CLK_OFF   = 3'd0;
  localparam logic [2:0] CLK_ON    = 3'd1;
  localparam logic [2:0] RST_PULSE = 3'd2;
  localparam logic [2:0] RST_OFF   = 3'd3;
  localparam logic [2:0] TX_SOC    = 3'd4;
  localparam logic [2:0] TX_CTRL   = 3'd5;
  localparam logic [2:0] RX_ON     = 3'd6;
  localparam logic [2:0] RX_OFF    = 3'd7;

  function automatic logic [7:0] cmd_byte(input logic [2:0] code);
    return {5'b0, code};
  endfunction

endpackage

// File: rtl/ci_uart_tx_ser.sv
// 8N1 serializer: start pulse loads a byte, line goes low on the next edge,
// done marks the final cycle of the stop bit.
module ci_uart_tx_ser #(
  parameter int BIT_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(BIT_CYCLES - 1));
  assign done    = busy_q && bit_end && (idx_q == 4'd9);
  assign busy    = busy_q;
  assign txd     = busy_q ? sh_q[0] : 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    if (start && !busy_q) begin
      // stop, data LSB first, start -- shifted out from bit 0
      sh_d   = {1'b1, data, 1'b0};
      cnt_d  = '0;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_d = '0;
        sh_d  = {1'b1, sh_q[9:1]};
        if (idx_q == 4'd9) busy_d = 1'b0;
        else               idx_d  = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '1;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ci_cmd_sender.sv
// Queues controller opcodes in a 4-deep FIFO and sends each as a UART byte,
// inserting a 0xFF guard byte after reset or before a repeated byte.
module ci_cmd_sender
  import ci_cmd_sender_pkg::*;
#(
  parameter int CLK_HZ   = 27000000,
  parameter int BIT_RATE = 9600,
  parameter int GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic [2:0] fifo_level,
  output logic       sent
);
  localparam int BIT_CYCLES = CLK_HZ / BIT_RATE;
  localparam int GAP_CYC    = GAP_BITS * BIT_CYCLES;
  localparam int GW         = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [3:0][2:0] mem_q, mem_d;
  logic [1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [2:0]      lvl_q, lvl_d;
  logic            push, pop;
  logic [7:0]      head;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d, last_q, last_d;
  logic            first_q, first_d;
  logic            pend_q, pend_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            ser_start, ser_busy, ser_done;
  logic [7:0]      ser_data;

  assign cmd_ready  = (lvl_q != 3'd4);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_level = lvl_q;
  assign head       = cmd_byte(mem_q[rd_q]);
  assign busy       = (lvl_q != 3'd0) || (state_q != IDLE);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) begin
      mem_d[wr_q] = cmd_code;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 3'd1;
      2'b01:   lvl_d = lvl_q - 3'd1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    last_d    = last_q;
    first_d   = first_q;
    pend_d    = pend_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    ser_start = 1'b0;
    ser_data  = cmd_q;
    sent      = 1'b0;
    case (state_q)
      IDLE: if (lvl_q != 3'd0) begin
        pop       = 1'b1;
        cmd_d     = head;
        ser_start = 1'b1;
        if (first_q || head == last_q) begin
          state_d  = GUARD;
          ser_data = GUARD_BYTE;
        end else begin
          state_d  = CMD;
          ser_data = head;
        end
      end
      GUARD: if (ser_done) begin
        last_d  = GUARD_BYTE;
        first_d = 1'b0;
        pend_d  = 1'b1;
        gap_d   = '0;
        state_d = GAP;
      end
      CMD: if (ser_done) begin
        last_d  = cmd_q;
        sent    = 1'b1;
        pend_d  = 1'b0;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          // a guarded command launches straight from the gap's last cycle
          if (pend_q) begin
            state_d   = CMD;
            ser_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      state_q <= IDLE;
      cmd_q   <= '0;
      last_q  <= GUARD_BYTE;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
    end
  end

  ci_uart_tx_ser #(.BIT_CYCLES(BIT_CYCLES)) u_ser (
    .clk   (clk),
    .reset (reset),
    .start (ser_start),
    .data  (ser_data),
    .txd   (uart_tx),
    .busy  (ser_busy),
    .done  (ser_done)
  );

  logic unused_ser_busy;
  assign unused_ser_busy = ser_busy;

endmodule

// File: tb/tb_ci_cmd_sender.sv
// Directed bench for ci_cmd_sender with a frame-decoding monitor and a byte scoreboard.
module tb_ci_cmd_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready, uart_tx, busy, sent;
  logic [2:0] fifo_level;

  int n_assert = 0;
  int n_fail   = 0;
  int n_sent_seen = 0;
  int n_sent_exp  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_last  = 8'hFF;
  bit         m_first = 1'b1;

  always #5 clk = ~clk;

  ci_cmd_sender #(.CLK_HZ(1000), .BIT_RATE(100), .GAP_BITS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .sent       (sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected byte stream: guard before the first byte after reset and before repeats
  task automatic model_push(input logic [2:0] code);
    logic [7:0] b;
    b = {5'b0, code};
    if (m_first || b == m_last) begin
      exp_q.push_back(8'hFF);
      m_first = 1'b0;
    end
    exp_q.push_back(b);
    m_last = b;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last  = 8'hFF;
    m_first = 1'b1;
  endtask

  task automatic push_cmd(input logic [2:0] code, input string tag);
    cmd_valid = 1'b1;
    cmd_code  = code;
    chk(tag, cmd_ready, 1);
    model_push(code);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 3000) ? 1 : 0, 1);
  endtask

  // frame monitor: mid-bit sampling plus a per-bit stability check
  int         mon_cyc;
  bit         in_frame = 1'b0;
  bit         width_ok;
  logic       cur_bit;
  logic [9:0] frm;
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_frame = 1'b0;
      end else begin
        if (sent === 1'b1) n_sent_seen++;
        if (!in_frame && uart_tx === 1'b0) begin
          in_frame = 1'b1;
          mon_cyc  = 0;
          width_ok = 1'b1;
          frm      = '0;
        end
        if (in_frame) begin
          if (mon_cyc % 10 == 0) cur_bit = uart_tx;
          else if (uart_tx !== cur_bit) width_ok = 1'b0;
          if (mon_cyc % 10 == 5) frm[mon_cyc / 10] = uart_tx;
          if (mon_cyc == 99) begin
            in_frame = 1'b0;
            chk("frame_width", width_ok, 1);
            chk("frame_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
              eb = exp_q.pop_front();
              chk("frame_bits", frm, {22'b0, 1'b1, eb, 1'b0});
              chk("sent_at_stop", sent, (eb != 8'hFF) ? 1 : 0);
              if (eb != 8'hFF) n_sent_exp++;
            end
          end else begin
            mon_cyc++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit gap_ok;
    logic [2:0] burst [5];
    logic [2:0] lv    [5];
    burst = '{3'd4, 3'd5, 3'd5, 3'd7, 3'd0};
    lv    = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    @(negedge clk);

    // first command after reset: guard, 10 idle cycles, then the command
    push_cmd(3'd1, "s1_ready");
    chk("s1_level_queued", fifo_level, 1);
    chk("s1_busy", busy, 1);
    chk("s1_tx_idle", uart_tx, 1);
    @(negedge clk);
    chk("s1_start_after_pop", uart_tx, 0);
    chk("s1_level_popped", fifo_level, 0);
    gap_ok = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      if (c >= 100 && c <= 109 && uart_tx !== 1'b1) gap_ok = 1'b0;
      if (c == 110) chk("s1_cmd_after_gap", uart_tx, 0);
    end
    chk("s1_gap_high", gap_ok, 1);
    wait_idle("s1_idle");

    // repeat detection
    push_cmd(3'd2, "s2_ready_a");
    wait_idle("s2_idle_a");
    push_cmd(3'd2, "s2_ready_b");
    wait_idle("s2_idle_b");
    push_cmd(3'd3, "s2_ready_c");
    wait_idle("s2_idle_c");

    // five back-to-back pushes fill the FIFO, the sixth waits for a pop
    for (int i = 0; i < 5; i++) begin
      push_cmd(burst[i], "s3_burst_ready");
      chk("s3_burst_level", fifo_level, lv[i]);
    end
    cmd_valid = 1'b1; cmd_code = 3'd1;
    chk("s3_full_ready", cmd_ready, 0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("s3_sixth_wait", (n < 400) ? 1 : 0, 1);
    chk("s3_level_after_pop", fifo_level, 3);
    model_push(3'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("s3_level_sixth", fifo_level, 4);
    wait_idle("s3_idle");

    // push in the pop cycle at level 2
    push_cmd(3'd2, "s4_ready_a");
    repeat (5) @(negedge clk);
    push_cmd(3'd3, "s4_ready_b");
    push_cmd(3'd4, "s4_ready_c");
    chk("s4_level_two", fifo_level, 2);
    n = 0;
    while (sent !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s4_sent_seen", (n < 300) ? 1 : 0, 1);
    repeat (11) @(negedge clk);
    chk("s4_level_before", fifo_level, 2);
    push_cmd(3'd5, "s4_ready_d");
    chk("s4_push_pop_level", fifo_level, 2);
    chk("s4_pop_started", uart_tx, 0);
    wait_idle("s4_idle");

    // reset 35 cycles into a frame
    push_cmd(3'd6, "s5_ready_a");
    push_cmd(3'd7, "s5_ready_b");
    n = 0;
    while (uart_tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s5_frame_start", (n < 50) ? 1 : 0, 1);
    repeat (35) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("s5_tx_high", uart_tx, 1);
    chk("s5_level", fifo_level, 0);
    chk("s5_busy", busy, 0);
    chk("s5_ready", cmd_ready, 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_cmd(3'd6, "s5_ready_c");
    wait_idle("s5_idle");

    chk("sent_count", n_sent_seen, n_sent_exp);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
